// File: rtl/lcd_msg_sequencer_if.sv
// Offer/accept bundle between lcd_msg_sequencer (master) and the LCD write driver side (slave).
// IDX_W must match the sequencer instance it is connected to.
interface lcd_msg_sequencer_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic             repeat_mode;
    logic             abort;
    logic             lcd_busy;
    logic             data_ready;
    logic [IDX_W-1:0] data_index;
    logic             line2_req;
    logic             active;
    logic             done;
    logic             timeout_err;

    modport master (
        input  start, repeat_mode, abort, lcd_busy,
        output data_ready, data_index, line2_req, active, done, timeout_err
    );

    modport slave (
        output start, repeat_mode, abort, lcd_busy,
        input  data_ready, data_index, line2_req, active, done, timeout_err
    );
endinterface

// File: rtl/lcd_msg_sequencer.sv
// Steps a message ROM index into an LCD write driver over a ready/busy handshake, with a
// line-2 cursor command after LINE_LEN characters. Optional busy watchdog: LCD_SEQ_TIMEOUT_EN.
module lcd_msg_sequencer #(
    parameter int MSG_LEN     = 32,
    parameter int LINE_LEN    = 16,
    parameter int IDX_W       = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                reset_button_n,
    lcd_msg_sequencer_if.master seq_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_OFFER,
        S_WAIT_RDY_CMD,
        S_OFFER_CMD,
        S_DONE
    } state_e;

    // Line-2 compare is only meaningful when the message spills past the first line; this
    // also keeps a truncated LINE_LEN-1 from aliasing onto a real index for short messages.
    localparam bit             HAS_LINE2    = (MSG_LEN > LINE_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] LINE_END_IDX = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0] LINE2_IDX    = IDX_W'(LINE_LEN);

    if (MSG_LEN < 1 || MSG_LEN > 2 * LINE_LEN || (2 ** IDX_W) < MSG_LEN || TIMEOUT_CYC < 1)
    begin : g_bad_cfg
        $error("lcd_msg_sequencer: illegal MSG_LEN/LINE_LEN/IDX_W/TIMEOUT_CYC combination");
    end

    state_e           state_q;
    logic [IDX_W-1:0] data_index_q;
    logic             data_ready_q;
    logic             line2_req_q;
    logic             active_q;
    logic             done_q;
    logic             timeout_hit;

    always_ff @(posedge clk or negedge reset_button_n) begin
        if (!reset_button_n) begin
            state_q      <= S_IDLE;
            data_index_q <= '0;
            data_ready_q <= 1'b0;
            line2_req_q  <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: default assignment makes done a single-cycle pulse without extra states.
            done_q <= 1'b0;
            if (seq_bus.abort || timeout_hit) begin
                state_q      <= S_IDLE;
                data_index_q <= '0;
                data_ready_q <= 1'b0;
                line2_req_q  <= 1'b0;
                active_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (seq_bus.start) begin
                            state_q      <= S_WAIT_RDY;
                            data_index_q <= '0;
                            active_q     <= 1'b1;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (!seq_bus.lcd_busy) begin
                            state_q      <= S_OFFER;
                            data_ready_q <= 1'b1;
                        end
                    end
                    S_OFFER: begin
                        if (seq_bus.lcd_busy) begin
                            data_ready_q <= 1'b0;
                            if (data_index_q == LAST_IDX) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else if (HAS_LINE2 && data_index_q == LINE_END_IDX) begin
                                state_q <= S_WAIT_RDY_CMD;
                            end else begin
                                state_q      <= S_WAIT_RDY;
                                data_index_q <= data_index_q + IDX_W'(1);
                            end
                        end
                    end
                    S_WAIT_RDY_CMD: begin
                        if (!seq_bus.lcd_busy) begin
                            state_q     <= S_OFFER_CMD;
                            line2_req_q <= 1'b1;
                        end
                    end
                    S_OFFER_CMD: begin
                        if (seq_bus.lcd_busy) begin
                            state_q      <= S_WAIT_RDY;
                            line2_req_q  <= 1'b0;
                            data_index_q <= LINE2_IDX;
                        end
                    end
                    S_DONE: begin
                        if (seq_bus.repeat_mode) begin
                            state_q      <= S_WAIT_RDY;
                            data_index_q <= '0;
                        end else begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            timeout_err_q;
    logic            stalled;

    // A stall is any cycle where the FSM is waiting on the driver and stays put.
    always_comb begin
        stalled = (((state_q == S_OFFER) || (state_q == S_OFFER_CMD)) && !seq_bus.lcd_busy) ||
                  (((state_q == S_WAIT_RDY) || (state_q == S_WAIT_RDY_CMD)) && seq_bus.lcd_busy);
        timeout_hit = stalled && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        to_cnt_d    = '0;
        if (stalled && !timeout_hit && !seq_bus.abort) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_button_n) begin
        if (!reset_button_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end else if (state_q == S_IDLE && seq_bus.start) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign seq_bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit         = 1'b0;
    assign seq_bus.timeout_err = 1'b0;
`endif

    assign seq_bus.data_ready = data_ready_q;
    assign seq_bus.data_index = data_index_q;
    assign seq_bus.line2_req  = line2_req_q;
    assign seq_bus.active     = active_q;
    assign seq_bus.done       = done_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: cycle vectors plus message-level sequences on four instances
// (32/16, 8/16, 1/16 and a TIMEOUT_CYC=16 watchdog instance) behind a shared stimulus mux.
module tb_lcd_msg_sequencer;

    localparam int L2_TOK = -1;

    logic clk;
    logic rst_n;
    logic [1:0] sel;
    logic start, repeat_mode, abort, lcd_busy;

    logic       dr, l2, act, dn_o, terr;
    logic [4:0] idx;
    logic [9:0] obs;

    int n_tests = 0;
    int n_fail  = 0;
    int got[$];
    int exp_q[$];
    int overlap_cnt;

    lcd_msg_sequencer_if #(.IDX_W(5)) if_a ();
    lcd_msg_sequencer_if #(.IDX_W(3)) if_b ();
    lcd_msg_sequencer_if #(.IDX_W(1)) if_c ();
    lcd_msg_sequencer_if #(.IDX_W(5)) if_t ();

    lcd_msg_sequencer #(.MSG_LEN(32), .LINE_LEN(16), .IDX_W(5), .TIMEOUT_CYC(4096)) u_a (
        .clk(clk), .reset_button_n(rst_n), .seq_bus(if_a));
    lcd_msg_sequencer #(.MSG_LEN(8), .LINE_LEN(16), .IDX_W(3), .TIMEOUT_CYC(4096)) u_b (
        .clk(clk), .reset_button_n(rst_n), .seq_bus(if_b));
    lcd_msg_sequencer #(.MSG_LEN(1), .LINE_LEN(16), .IDX_W(1), .TIMEOUT_CYC(4096)) u_c (
        .clk(clk), .reset_button_n(rst_n), .seq_bus(if_c));
    lcd_msg_sequencer #(.MSG_LEN(32), .LINE_LEN(16), .IDX_W(5), .TIMEOUT_CYC(16)) u_t (
        .clk(clk), .reset_button_n(rst_n), .seq_bus(if_t));

    assign if_a.start = start & (sel == 2'd0);
    assign if_b.start = start & (sel == 2'd1);
    assign if_c.start = start & (sel == 2'd2);
    assign if_t.start = start & (sel == 2'd3);
    assign if_a.abort = abort & (sel == 2'd0);
    assign if_b.abort = abort & (sel == 2'd1);
    assign if_c.abort = abort & (sel == 2'd2);
    assign if_t.abort = abort & (sel == 2'd3);
    assign if_a.lcd_busy = lcd_busy & (sel == 2'd0);
    assign if_b.lcd_busy = lcd_busy & (sel == 2'd1);
    assign if_c.lcd_busy = lcd_busy & (sel == 2'd2);
    assign if_t.lcd_busy = lcd_busy & (sel == 2'd3);
    assign if_a.repeat_mode = repeat_mode;
    assign if_b.repeat_mode = repeat_mode;
    assign if_c.repeat_mode = repeat_mode;
    assign if_t.repeat_mode = repeat_mode;

    always_comb begin
        dr = 1'b0; l2 = 1'b0; act = 1'b0; dn_o = 1'b0; terr = 1'b0; idx = '0;
        case (sel)
            2'd0: begin dr = if_a.data_ready; l2 = if_a.line2_req; act = if_a.active;
                        dn_o = if_a.done; terr = if_a.timeout_err; idx = if_a.data_index; end
            2'd1: begin dr = if_b.data_ready; l2 = if_b.line2_req; act = if_b.active;
                        dn_o = if_b.done; terr = if_b.timeout_err; idx = 5'(if_b.data_index); end
            2'd2: begin dr = if_c.data_ready; l2 = if_c.line2_req; act = if_c.active;
                        dn_o = if_c.done; terr = if_c.timeout_err; idx = 5'(if_c.data_index); end
            default: begin dr = if_t.data_ready; l2 = if_t.line2_req; act = if_t.active;
                        dn_o = if_t.done; terr = if_t.timeout_err; idx = if_t.data_index; end
        endcase
    end

    assign obs = {dr, l2, idx, act, dn_o, terr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        bit         start;
        bit         busy;
        bit         abort;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [9:0] mk(input bit d, input bit l, input int i, input bit a,
                                      input bit dn);
        return {d, l, 5'(i), a, dn, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Driver model: accepts each offer 3 cycles after it appears; records accepted tokens.
    task automatic serve(input int budget, input int n_done, input int clr_rep_at,
                         input int stop_idx, output int dn_cnt, output bit stopped);
        int  wait_cnt;
        bit  clr_pending;
        wait_cnt    = 0;
        clr_pending = 1'b0;
        dn_cnt      = 0;
        stopped     = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            if (clr_pending) begin
                repeat_mode = 1'b0;
                clr_pending = 1'b0;
            end
            if (dr && l2) overlap_cnt++;
            if (lcd_busy) begin
                lcd_busy = 1'b0;
            end else if (dr || l2) begin
                if (stop_idx >= 0 && dr && int'(idx) == stop_idx) begin
                    stopped = 1'b1;
                    return;
                end
                wait_cnt++;
                if (wait_cnt == 3) begin
                    lcd_busy = 1'b1;
                    wait_cnt = 0;
                    got.push_back(l2 ? L2_TOK : int'(idx));
                end
            end
            if (dn_o) begin
                dn_cnt++;
                if (dn_cnt == clr_rep_at) clr_pending = 1'b1;
                if (dn_cnt == n_done) return;
            end
        end
    endtask

    task automatic build_exp(input int msg_len, input int line_len, input int n_msg);
        exp_q.delete();
        for (int m = 0; m < n_msg; m++) begin
            for (int i = 0; i < msg_len; i++) begin
                if (msg_len > line_len && i == line_len) exp_q.push_back(L2_TOK);
                exp_q.push_back(i);
            end
        end
    endtask

    task automatic cmp_seq(input string name);
        int nm;
        nm = 0;
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i] != exp_q[i]) nm++;
        end
        check({name, "_mism"}, nm, 0);
        check({name, "_overlap"}, overlap_cnt, 0);
    endtask

    initial begin
        int  dn_cnt;
        bit  stopped;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "v00_idle"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, mk(0, 0, 0, 1, 0), "v01_start"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 1, 0), "v02_wait_busy"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0), "v03_offer0"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0), "v04_hold0"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0), "v05_accept0"};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, mk(0, 0, 1, 1, 0), "v06_start_ignored"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 1, 1, 0), "v07_offer1"};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0), "v08_abort_over_accept"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 0), "v09_restart"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0), "v10_offer0"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0), "v11_abort_offer"};
        vecs[12] = '{1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0), "v12_abort_over_start"};
        vecs[13] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "v13_idle"};

        sel = 2'd0; start = 1'b0; repeat_mode = 1'b0; abort = 1'b0; lcd_busy = 1'b0;
        overlap_cnt = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs, 10'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start    = vecs[i].start;
            lcd_busy = vecs[i].busy;
            abort    = vecs[i].abort;
            @(posedge clk); #1;
            check(vecs[i].name, obs, vecs[i].exp);
        end
        start = 1'b0; lcd_busy = 1'b0; abort = 1'b0;

        // Full 32-char message, then start during DONE must be ignored.
        got.delete(); overlap_cnt = 0;
        pulse_start();
        serve(400, 1, 0, -1, dn_cnt, stopped);
        check("msg32_done_cnt", dn_cnt, 1);
        check("msg32_done_cycle", {act, idx}, {1'b1, 5'd31});
        build_exp(32, 16, 1);
        cmp_seq("msg32");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("msg32_idle_after_done", {act, dn_o, dr, idx}, {1'b0, 1'b0, 1'b0, 5'd31});
        @(posedge clk); #1;
        check("msg32_start_in_done_ignored", act, 1'b0);

        // Repeat mode: two messages, cleared during the second.
        got.delete(); overlap_cnt = 0;
        repeat_mode = 1'b1;
        pulse_start();
        serve(800, 2, 1, -1, dn_cnt, stopped);
        check("repeat_done_cnt", dn_cnt, 2);
        build_exp(32, 16, 2);
        cmp_seq("repeat");
        @(posedge clk); #1;
        check("repeat_idle_after", {act, repeat_mode}, 2'b00);

        // Abort at index 9 in the same cycle as the driver accepts.
        got.delete(); overlap_cnt = 0;
        pulse_start();
        serve(200, 1, 0, 9, dn_cnt, stopped);
        check("abort_reached_idx9", {stopped, dr, idx}, {1'b1, 1'b1, 5'd9});
        lcd_busy = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        lcd_busy = 1'b0; abort = 1'b0;
        check("abort_outputs", obs, 10'd0);
        dn_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dn_o || act) dn_cnt++;
        end
        check("abort_no_done", dn_cnt, 0);

        // Asynchronous reset between edges while offering.
        pulse_start();
        @(posedge clk); #1;
        check("reset_mid_offer_pre", {dr, act}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_outputs", obs, 10'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("reset_start_blocked", obs, 10'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_released_idle", act, 1'b0);

        // Short message: no line-2 command.
        sel = 2'd1;
        got.delete(); overlap_cnt = 0;
        pulse_start();
        serve(200, 1, 0, -1, dn_cnt, stopped);
        check("msg8_done_cnt", dn_cnt, 1);
        build_exp(8, 16, 1);
        cmp_seq("msg8");
        @(posedge clk); #1;
        check("msg8_idle", {act, idx}, {1'b0, 5'd7});

        // Single-character message.
        sel = 2'd2;
        got.delete(); overlap_cnt = 0;
        pulse_start();
        serve(50, 1, 0, -1, dn_cnt, stopped);
        check("msg1_done_cnt", dn_cnt, 1);
        build_exp(1, 16, 1);
        cmp_seq("msg1");
        @(posedge clk); #1;
        check("msg1_idle", act, 1'b0);

        // Busy watchdog instance, driver never accepts.
        sel = 2'd3;
        pulse_start();
        @(posedge clk); #1;
        check("wd_offer", {dr, terr}, 2'b10);
`ifdef LCD_SEQ_TIMEOUT_EN
        repeat (15) @(posedge clk);
        #1;
        check("wd_before_limit", {dr, act, terr}, 3'b110);
        @(posedge clk); #1;
        check("wd_tripped", {dr, act, terr, idx}, {3'b001, 5'd0});
        pulse_start();
        check("wd_cleared_by_start", {act, terr}, 2'b10);
`else
        repeat (40) @(posedge clk);
        #1;
        check("wd_absent_waits", {dr, act, terr}, 3'b110);
`endif
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("wd_final_abort", obs[9:1], 9'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
